// File: rtl/regfile_pkg.sv
// Shared definitions for the register file write-port scheduler: sizes,
// FSM state encoding and the write-port grant source.
package regfile_pkg;

  localparam int unsigned NREGS    = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned REG_ZERO = 0;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    CLR  = 2'd1,
    CORE = 2'd2,
    DBG  = 2'd3
  } grant_t;

endpackage

// File: rtl/regfile_write_scheduler_starve_counter.sv
// Counts consecutive cycles a debug request waits; raises force_dbg for the
// cycle after the wait count reaches LIMIT.
module starve_counter #(
  parameter int unsigned LIMIT = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic dbg_valid,
  input  logic dbg_ready,
  output logic force_dbg
);

  logic [7:0] cnt;
  logic [7:0] cnt_inc;
  logic       waiting;

  assign waiting = en && dbg_valid && !dbg_ready;
  assign cnt_inc = (cnt == 8'hFF) ? cnt : cnt + 8'd1;

  // A force cycle always either accepts debug or sees it dropped, so waiting
  // is low there and both the count and force clear on the following edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      force_dbg <= 1'b0;
    end else begin
      cnt       <= waiting ? cnt_inc : '0;
      force_dbg <= waiting && (32'(cnt_inc) >= LIMIT);
    end
  end

endmodule

// File: rtl/regfile_write_scheduler.sv
// Owns the register file write port: clears x1..x31 after reset, then
// arbitrates core writeback (priority) against a starvation-protected debug writer.
module regfile_write_scheduler #(
  parameter int unsigned NREGS        = regfile_pkg::NREGS,
  parameter int unsigned ADDR_W       = regfile_pkg::ADDR_W,
  parameter int unsigned DATA_W       = regfile_pkg::DATA_W,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_rd,
  input  logic [DATA_W-1:0] core_wdata,
  input  logic              dbg_valid,
  input  logic [ADDR_W-1:0] dbg_rd,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ready,
  output logic              core_stall,
  output logic              init_done,
  output logic              rf_write_signal,
  output logic [ADDR_W-1:0] rf_write_reg,
  output logic [DATA_W-1:0] rf_write_data
);

  import regfile_pkg::*;

  state_t            state;
  logic [ADDR_W-1:0] clr_cnt;
  logic              force_dbg;
  grant_t            grant;
  logic              core_wr_ok;

  assign core_wr_ok = core_we && (core_rd != ADDR_W'(REG_ZERO));
  assign init_done  = (state == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= CLEAR;
      clr_cnt <= ADDR_W'(1);
    end else if (state == CLEAR) begin
      clr_cnt <= clr_cnt + ADDR_W'(1);
      if (clr_cnt == ADDR_W'(NREGS - 1)) state <= RUN;
    end
  end

  // The reset state alone would present the first clear write, so the
  // port is explicitly held idle while rst_n is low.
  always_comb begin
    grant      = NONE;
    dbg_ready  = 1'b0;
    core_stall = 1'b1;
    if (rst_n) begin
      if (state == CLEAR) begin
        grant = CLR;
      end else begin
        core_stall = force_dbg;
        if (force_dbg) begin
          if (dbg_valid) begin
            grant     = DBG;
            dbg_ready = 1'b1;
          end
        end else if (core_wr_ok) begin
          grant = CORE;
        end else if (dbg_valid) begin
          grant     = DBG;
          dbg_ready = 1'b1;
        end
      end
    end
  end

  always_comb begin
    rf_write_signal = 1'b0;
    rf_write_reg    = '0;
    rf_write_data   = '0;
    case (grant)
      CLR: begin
        rf_write_signal = 1'b1;
        rf_write_reg    = clr_cnt;
      end
      CORE: begin
        rf_write_signal = 1'b1;
        rf_write_reg    = core_rd;
        rf_write_data   = core_wdata;
      end
      DBG: begin
        if (dbg_rd != ADDR_W'(REG_ZERO)) begin
          rf_write_signal = 1'b1;
          rf_write_reg    = dbg_rd;
          rf_write_data   = dbg_wdata;
        end
      end
      default: ;
    endcase
  end

  starve_counter #(
    .LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (state == RUN),
    .dbg_valid(dbg_valid),
    .dbg_ready(dbg_ready),
    .force_dbg(force_dbg)
  );

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Self-checking bench for regfile_write_scheduler: table vectors, hand-written
// clear/starvation/reset sequences and randomized traffic against a reference model.
module tb_regfile_write_scheduler;

  localparam int LIMIT = 8;
  localparam int NR    = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        core_we = 1'b0;
  logic [4:0]  core_rd = '0;
  logic [31:0] core_wdata = '0;
  logic        dbg_valid = 1'b0;
  logic [4:0]  dbg_rd = '0;
  logic [31:0] dbg_wdata = '0;
  logic        dbg_ready, core_stall, init_done, rf_write_signal;
  logic [4:0]  rf_write_reg;
  logic [31:0] rf_write_data;

  always #5 clk = ~clk;

  regfile_write_scheduler #(
    .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .core_we        (core_we),
    .core_rd        (core_rd),
    .core_wdata     (core_wdata),
    .dbg_valid      (dbg_valid),
    .dbg_rd         (dbg_rd),
    .dbg_wdata      (dbg_wdata),
    .dbg_ready      (dbg_ready),
    .core_stall     (core_stall),
    .init_done      (init_done),
    .rf_write_signal(rf_write_signal),
    .rf_write_reg   (rf_write_reg),
    .rf_write_data  (rf_write_data)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] shadow [NR];
  logic [31:0] mref   [NR];

  // Reference model: clear progress, consecutive debug wait cycles, force flag.
  bit m_clear;
  int m_idx;
  int m_wait;
  bit m_force;

  logic        e_we, e_rdy, e_stall, e_done;
  logic [4:0]  e_reg;
  logic [31:0] e_data;
  logic        c_we, c_rdy, c_stall, c_done;
  logic [4:0]  c_reg;
  logic [31:0] c_data;

  typedef struct {
    logic        cwe;
    logic [4:0]  crd;
    logic [31:0] cwd;
    logic        dv;
    logic [4:0]  drd;
    logic [31:0] dwd;
    logic        x_we;
    logic [4:0]  x_reg;
    logic [31:0] x_data;
    logic        x_rdy;
    logic        x_stall;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_clear = 1'b1;
    m_idx   = 1;
    m_wait  = 0;
    m_force = 1'b0;
  endtask

  task automatic model_predict(input logic cwe, input logic [4:0] crd, input logic [31:0] cwd,
                               input logic dv, input logic [4:0] drd, input logic [31:0] dwd);
    e_we = 0; e_reg = '0; e_data = '0; e_rdy = 0; e_stall = 1; e_done = 0;
    if (m_clear) begin
      e_we  = 1;
      e_reg = 5'(m_idx);
    end else begin
      e_done  = 1;
      e_stall = m_force;
      if (m_force || !(cwe && crd != 0)) begin
        if (dv) begin
          e_rdy = 1;
          if (drd != 0) begin e_we = 1; e_reg = drd; e_data = dwd; end
        end
      end else begin
        e_we = 1; e_reg = crd; e_data = cwd;
      end
    end
  endtask

  task automatic model_commit(input logic dv);
    if (e_we) mref[e_reg] = e_data;
    if (m_clear) begin
      m_idx++;
      if (m_idx == NR) m_clear = 1'b0;
    end else if (m_force) begin
      m_force = 1'b0;
      m_wait  = 0;
    end else if (dv && !e_rdy) begin
      m_wait++;
      if (m_wait >= LIMIT) m_force = 1'b1;
    end else begin
      m_wait = 0;
    end
  endtask

  // One clock cycle, entered and left at the falling edge.
  task automatic cyc(input logic cwe, input logic [4:0] crd, input logic [31:0] cwd,
                     input logic dv, input logic [4:0] drd, input logic [31:0] dwd,
                     input bit check);
    core_we = cwe; core_rd = crd; core_wdata = cwd;
    dbg_valid = dv; dbg_rd = drd; dbg_wdata = dwd;
    #1;
    model_predict(cwe, crd, cwd, dv, drd, dwd);
    c_we = rf_write_signal; c_reg = rf_write_reg; c_data = rf_write_data;
    c_rdy = dbg_ready; c_stall = core_stall; c_done = init_done;
    if (check) begin
      chk("m_we", c_we, e_we);
      if (e_we) begin
        chk("m_reg", c_reg, e_reg);
        chk("m_data", c_data, e_data);
      end
      chk("m_rdy", c_rdy, e_rdy);
      chk("m_stall", c_stall, e_stall);
      chk("m_done", c_done, e_done);
    end
    @(posedge clk);
    if (c_we) shadow[c_reg] = c_data;
    model_commit(dv);
    @(negedge clk);
  endtask

  task automatic idle(input bit check);
    cyc(1'b0, '0, '0, 1'b0, '0, '0, check);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_we"}, rf_write_signal, 1'b0);
    chk({tag, "_reg"}, rf_write_reg, 5'd0);
    chk({tag, "_data"}, rf_write_data, 32'd0);
    chk({tag, "_rdy"}, dbg_ready, 1'b0);
    chk({tag, "_stall"}, core_stall, 1'b1);
    chk({tag, "_done"}, init_done, 1'b0);
  endtask

  task automatic run_clear(input string tag);
    int n_wr = 0;
    for (int i = 0; i < NR - 1; i++) begin
      idle(1'b1);
      if (c_we) n_wr++;
      if (i == 0) chk({tag, "_first_idx"}, c_reg, 5'd1);
    end
    chk({tag, "_writes"}, n_wr, 31);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1, 5'd5,  32'hDEADBEEF, 1, 5'd7,  32'h00001111, 1, 5'd5,  32'hDEADBEEF, 0, 0};
    vecs[1] = '{1, 5'd0,  32'h0BADF00D, 1, 5'd7,  32'h12345678, 1, 5'd7,  32'h12345678, 1, 0};
    vecs[2] = '{0, 5'd0,  32'h0,        1, 5'd0,  32'h00000055, 0, 5'd0,  32'h0,        1, 0};
    vecs[3] = '{0, 5'd4,  32'h44,       0, 5'd6,  32'h66,       0, 5'd0,  32'h0,        0, 0};
    vecs[4] = '{1, 5'd31, 32'hCAFEF00D, 0, 5'd0,  32'h0,        1, 5'd31, 32'hCAFEF00D, 0, 0};
    vecs[5] = '{1, 5'd0,  32'h77777777, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 0};
    vecs[6] = '{0, 5'd0,  32'h0,        1, 5'd31, 32'hFFFFFFFF, 1, 5'd31, 32'hFFFFFFFF, 1, 0};
    vecs[7] = '{1, 5'd1,  32'h0,        1, 5'd2,  32'h000000AB, 1, 5'd1,  32'h0,        0, 0};
    vecs[8] = '{0, 5'd0,  32'h0,        1, 5'd2,  32'h000000AB, 1, 5'd2,  32'h000000AB, 1, 0};

    for (int i = 0; i < NR; i++) begin
      shadow[i] = (i == 0) ? 32'd0 : (32'hBAD00000 | 32'(i));
      mref[i]   = shadow[i];
    end

    // Reset with requests present: port must stay idle.
    rst_n = 1'b0; core_we = 1'b1; core_rd = 5'd3; dbg_valid = 1'b1; dbg_rd = 5'd4;
    #1;
    chk_reset_outputs("rst");
    @(negedge clk); @(negedge clk);
    core_we = 1'b0; dbg_valid = 1'b0;
    rst_n = 1'b1;
    model_reset();

    run_clear("clr");
    #1;
    chk("run_done", init_done, 1'b1);
    chk("run_stall", core_stall, 1'b0);
    chk("run_idle_we", rf_write_signal, 1'b0);
    for (int i = 1; i < NR; i++) chk("clr_zero", shadow[i], 32'd0);
    @(negedge clk);

    for (int v = 0; v < 9; v++) begin
      cyc(vecs[v].cwe, vecs[v].crd, vecs[v].cwd, vecs[v].dv, vecs[v].drd, vecs[v].dwd, 1'b1);
      chk("tbl_we", c_we, vecs[v].x_we);
      if (vecs[v].x_we) begin
        chk("tbl_reg", c_reg, vecs[v].x_reg);
        chk("tbl_data", c_data, vecs[v].x_data);
      end
      chk("tbl_rdy", c_rdy, vecs[v].x_rdy);
      chk("tbl_stall", c_stall, vecs[v].x_stall);
    end
    chk("x5", shadow[5], 32'hDEADBEEF);
    chk("x7", shadow[7], 32'h12345678);
    chk("x0", shadow[0], 32'd0);

    // Core hogs the port; debug gets a forced slot on the ninth cycle.
    for (int k = 1; k <= 10; k++) begin
      cyc(1'b1, 5'd3, 32'h300 + 32'(k), (k <= 9), 5'd9, 32'h99, 1'b1);
      if (k <= 8) begin
        chk("stv_reg", c_reg, 5'd3);
        chk("stv_rdy", c_rdy, 1'b0);
        chk("stv_stall", c_stall, 1'b0);
      end else if (k == 9) begin
        chk("stv_f_stall", c_stall, 1'b1);
        chk("stv_f_rdy", c_rdy, 1'b1);
        chk("stv_f_reg", c_reg, 5'd9);
        chk("stv_f_data", c_data, 32'h99);
      end else begin
        chk("stv_resume_reg", c_reg, 5'd3);
        chk("stv_resume_stall", c_stall, 1'b0);
      end
    end
    chk("x9", shadow[9], 32'h99);

    // Debug abandons its request just as the force cycle arrives.
    for (int k = 1; k <= 10; k++) begin
      cyc(1'b1, 5'd3, 32'h500 + 32'(k), (k <= 8), 5'd10, 32'hAA, 1'b1);
      if (k == 9) begin
        chk("drop_stall", c_stall, 1'b1);
        chk("drop_we", c_we, 1'b0);
        chk("drop_rdy", c_rdy, 1'b0);
      end else if (k == 10) begin
        chk("drop_resume_stall", c_stall, 1'b0);
        chk("drop_resume_reg", c_reg, 5'd3);
      end
    end

    // Randomized traffic; core holds while stalled, debug holds until accepted.
    begin
      logic        rcwe = 0, rdv = 0;
      logic [4:0]  rcrd = '0, rdrd = '0;
      logic [31:0] rcwd = '0, rdwd = '0;
      bit          hold_core = 0;
      for (int n = 0; n < 400; n++) begin
        if (!hold_core) begin
          rcwe = ($urandom_range(0, 9) < 7);
          rcrd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
          rcwd = $urandom;
        end
        if (!rdv) begin
          rdv  = ($urandom_range(0, 2) == 0);
          rdrd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
          rdwd = $urandom;
        end
        cyc(rcwe, rcrd, rcwd, rdv, rdrd, rdwd, 1'b1);
        hold_core = c_stall && rcwe;
        if (c_rdy) rdv = 1'b0;
      end
    end
    idle(1'b1);

    // Reset pulsed in the middle of the clear sequence.
    rst_n = 1'b0;
    #1;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 9; i++) idle(1'b1);
    core_we = 1'b1; core_rd = 5'd3; dbg_valid = 1'b1; dbg_rd = 5'd4;
    #1;
    chk("midclr_pre_we", rf_write_signal, 1'b1);
    chk("midclr_pre_idx", rf_write_reg, 5'd10);
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midclr");
    @(negedge clk); @(negedge clk);
    core_we = 1'b0; dbg_valid = 1'b0;
    rst_n = 1'b1;
    model_reset();
    run_clear("reclr");

    // Debug write to x0 after the restarted clear.
    cyc(1'b0, '0, '0, 1'b1, 5'd0, 32'hFEEDFACE, 1'b1);
    chk("dx0_rdy", c_rdy, 1'b1);
    chk("dx0_we", c_we, 1'b0);
    chk("dx0_x0", shadow[0], 32'd0);
    idle(1'b1);

    for (int i = 0; i < NR; i++) chk("final_rf", shadow[i], mref[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_write_scheduler.md
Name: regfile_write_scheduler

Overview:
Owns the single write port of the 32x32 register file. After reset it sequences a hardware clear of x1..x31, because the register array has no reset of its own. It then shares the write port between core writeback and a debug/loader writer. Core writeback has priority, and a starvation limit guarantees debug progress.

Parameters:
NREGS, 32, number of architectural registers (x0 hardwired zero)
ADDR_W, 5, register index width (log2 NREGS)
DATA_W, 32, register data width
STARVE_LIMIT, 8, consecutive debug wait cycles before a forced debug grant (1..255)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
core_we  in  1  core writeback request
core_rd  in  ADDR_W  core destination register
core_wdata  in  DATA_W  core writeback data
dbg_valid  in  1  debug write request (valid/ready)
dbg_rd  in  ADDR_W  debug destination register
dbg_wdata  in  DATA_W  debug write data
dbg_ready  out  1  debug write accepted this cycle
core_stall  out  1  core must hold its request; its write is not performed this cycle
init_done  out  1  clear sequence complete, register file valid
rf_write_signal  out  1  register file write enable
rf_write_reg  out  ADDR_W  register file write index
rf_write_data  out  DATA_W  register file write data

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (rst_n).
- State registers: state {CLEAR, RUN}, clr_cnt[ADDR_W], starve_cnt[8], force.
- Reset values:
  - State: state=CLEAR, clr_cnt=1, starve_cnt=0, force=0.
  - Outputs while rst_n=0: rf_write_signal=0, rf_write_reg=0, rf_write_data=0, dbg_ready=0, core_stall=1, init_done=0.
- rf_* outputs, dbg_ready and core_stall are combinational from state and inputs.
  - Zero added latency: the granted write lands at the same rising edge it is presented.
- CLEAR state:
  - Outputs: rf_write_signal=1, rf_write_reg=clr_cnt, rf_write_data=0, core_stall=1, dbg_ready=0.
  - clr_cnt increments each edge.
  - After the edge that writes index NREGS-1, go to RUN. This takes 31 edges.
  - x0 is never written.
- RUN state: init_done=1. Grant rules in priority order:
  1. force=1: grant debug if dbg_valid; core_stall=1; clear force and starve_cnt.
  2. core_we=1 and core_rd!=0: grant core; dbg_ready=0.
  3. dbg_valid=1: grant debug; dbg_ready=1.
  4. Otherwise: rf_write_signal=0.
- A core write to x0 is a no-op that does not occupy the port. Debug may be granted in the same cycle.
- A debug write to x0 completes the handshake (dbg_ready=1) with rf_write_signal=0.
- Starvation counter:
  - starve_cnt increments on each cycle with dbg_valid=1 and dbg_ready=0.
  - It clears when dbg_ready=1 or dbg_valid=0.
  - When starve_cnt reaches STARVE_LIMIT, force is set for the next cycle.
  - force clears if dbg_valid has dropped by then.
- core_stall=0 in RUN except in force cycles.
- Core must hold core_we, core_rd and core_wdata while core_stall=1. Debug must hold its request until dbg_ready.
- rst_n asserted mid-clear or mid-RUN: immediate return to the reset values, and the full clear restarts after deassertion.

Decomposition:
- Shared package regfile_pkg:
  - NREGS, ADDR_W, DATA_W, REG_ZERO=0.
  - State encoding: CLEAR=1'b0, RUN=1'b1.
  - Grant-source encoding: NONE, CLR, CORE, DBG.
- One natural sub-module: starve_counter (saturating wait counter with limit compare and force output).
- FSM and write mux stay in the top module.

Test Plan:
- Reset release, no requests -> rf_write_signal=1 for exactly 31 cycles with indices 1..31 and data 0, then init_done=1 and core_stall=0. x1..x31 read 0.
- RUN, core_we=1, core_rd=5, core_wdata=0xDEADBEEF -> same edge writes x5=0xDEADBEEF; dbg_ready=0 if dbg_valid.
- core_we=1 with core_rd=0, plus dbg_valid=1, dbg_rd=7, dbg_wdata=0x12345678 -> debug granted, x7=0x12345678, x0 stays 0.
- core_we held 1 (rd=3) continuously, dbg_valid=1 (rd=9) -> debug waits 8 cycles, then in cycle 9 core_stall=1, dbg_ready=1 and x9 is written. The core write resumes the next cycle.
- rst_n pulsed low at clear cycle 10 -> outputs return to reset values asynchronously; after release, the clear restarts from index 1 with 31 writes.
- dbg write to x0 in RUN -> dbg_ready=1, rf_write_signal=0, x0 reads 0.
